// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a frame of WIDTH-bit beats into one AND/OR/XOR (or inverted) result bit.
// Latency 1 cycle after the final beat; in_ready drops while a result waits for out_ready.
// Optional per-bit masking via in_mask when LOGIC_REDUCE_MASK_EN is defined.
module logic_reduce_unit #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 8,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef LOGIC_REDUCE_MASK_EN
  input  logic [WIDTH-1:0] in_mask,
`endif
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  state_t           state;
  logic [2:0]       frame_mode;
  logic             acc;
  logic [CNT_W-1:0] count;

  logic [2:0]       eff_mode;
  logic [1:0]       op;
  logic             inv;
  logic [WIDTH-1:0] beat_dat;
  logic             beat_red;
  logic             acc_next;
  logic [CNT_W-1:0] count_next;
  logic             at_max;
  logic             accept;

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;
  // The first beat of a frame decodes the live mode; later beats use the latched copy.
  assign eff_mode = (state == IDLE) ? mode : frame_mode;

  always_comb begin
    op  = OP_AND;
    inv = 1'b0;
    case (eff_mode)
      3'd1:    op = OP_OR;
      3'd2:    op = OP_XOR;
      3'd3:    inv = 1'b1;
      3'd4:    begin op = OP_OR;  inv = 1'b1; end
      3'd5:    begin op = OP_XOR; inv = 1'b1; end
      default: op = OP_AND;
    endcase
  end

  always_comb begin
    beat_dat = in_data;
`ifdef LOGIC_REDUCE_MASK_EN
    // Masked bits become the identity of the base op so they cannot affect the result.
    beat_dat = (op == OP_AND) ? (in_data | in_mask) : (in_data & ~in_mask);
`endif
    case (op)
      OP_OR:   beat_red = |beat_dat;
      OP_XOR:  beat_red = ^beat_dat;
      default: beat_red = &beat_dat;
    endcase

    if (state == IDLE) begin
      acc_next = beat_red;
    end else begin
      case (op)
        OP_OR:   acc_next = acc | beat_red;
        OP_XOR:  acc_next = acc ^ beat_red;
        default: acc_next = acc & beat_red;
      endcase
    end

    count_next = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
    at_max     = (count_next == CNT_W'(MAX_BEATS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_mode <= 3'd0;
      acc        <= 1'b0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_y      <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state == IDLE) frame_mode <= mode;
            acc   <= acc_next;
            count <= count_next;
            if (in_last || at_max) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_y     <= acc_next ^ inv;
              out_count <= count_next;
              out_err   <= !in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
